// File: rtl/gnrl_slot_alloc_module_if.sv
// ============================================================================
// gnrl_slot_alloc_module_if : request/offer bundle of the slot allocator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface gnrl_slot_alloc_module_if #(
    parameter int ENTRIES = 64,
    parameter int SEL     = 4
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int REQ_W = $clog2(SEL + 1);

    logic                   i_flush;
    logic [REQ_W-1:0]       i_alloc_cnt;
    logic [ENTRIES-1:0]     i_rls_vec;
    logic [SEL*IDX_W-1:0]   o_alloc_idx;
    logic [SEL-1:0]         o_alloc_vld;
    logic                   o_alloc_rdy;
    logic [CNT_W-1:0]       o_free_cnt;
    logic                   o_dbl_rls;

    modport master (
        output i_flush, i_alloc_cnt, i_rls_vec,
        input  o_alloc_idx, o_alloc_vld, o_alloc_rdy, o_free_cnt, o_dbl_rls
    );

    modport slave (
        input  i_flush, i_alloc_cnt, i_rls_vec,
        output o_alloc_idx, o_alloc_vld, o_alloc_rdy, o_free_cnt, o_dbl_rls
    );
endinterface

`default_nettype wire

// File: rtl/gnrl_slot_alloc_module.sv
// ============================================================================
// gnrl_slot_alloc_module : free-bitmap allocator offering the SEL lowest free
// slots per cycle, with all-or-nothing grant, release, flush and free count.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gnrl_slot_alloc_module #(
    parameter int ENTRIES = 64,
    parameter int SEL     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gnrl_slot_alloc_module_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int REQ_W = $clog2(SEL + 1);

    logic [ENTRIES-1:0]     r_free_map;
    logic [CNT_W-1:0]       r_free_cnt;
    logic                   r_dbl_rls;

    logic [SEL*IDX_W-1:0]   w_alloc_idx;
    logic [SEL-1:0]         w_alloc_vld;
    logic [REQ_W-1:0]       w_offer_cnt;
    logic [ENTRIES-1:0]     w_take;
    logic                   w_alloc_rdy;
    logic                   w_grant;
    logic [ENTRIES-1:0]     w_valid_rls;
    logic                   w_dbl_rls;
    logic [CNT_W-1:0]       w_rls_cnt;
    logic [CNT_W-1:0]       w_grant_cnt;
    logic [ENTRIES-1:0]     w_free_map_nxt;
    logic [CNT_W-1:0]       w_free_cnt_nxt;

    // Single ascending scan: the n-th free slot found feeds lane n, and is
    // marked for taking when n falls below the requested count.
    always_comb begin
        w_alloc_idx = '0;
        w_alloc_vld = '0;
        w_offer_cnt = '0;
        w_take      = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            if (r_free_map[j] && (w_offer_cnt < REQ_W'(SEL))) begin
                for (int k = 0; k < SEL; k++) begin
                    if (w_offer_cnt == REQ_W'(k)) begin
                        w_alloc_vld[k]                 = 1'b1;
                        w_alloc_idx[k*IDX_W +: IDX_W]  = IDX_W'(j);
                    end
                end
                w_take[j]   = (w_offer_cnt < bus.i_alloc_cnt);
                w_offer_cnt = w_offer_cnt + REQ_W'(1);
            end
        end
    end

    // Requests above SEL can never fit under w_offer_cnt, so they read as not ready.
    assign w_alloc_rdy = (bus.i_alloc_cnt <= w_offer_cnt);
    assign w_grant     = w_alloc_rdy && (bus.i_alloc_cnt != '0);
    assign w_valid_rls = bus.i_rls_vec & ~r_free_map;
    assign w_dbl_rls   = |(bus.i_rls_vec & r_free_map);
    assign w_grant_cnt = w_grant ? CNT_W'(bus.i_alloc_cnt) : '0;

    always_comb begin
        w_rls_cnt = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            w_rls_cnt = w_rls_cnt + CNT_W'(w_valid_rls[j]);
        end
    end

    // Granted slots are free and released slots are busy, so the two masks never overlap.
    assign w_free_map_nxt = (r_free_map & ~(w_take & {ENTRIES{w_grant}})) | w_valid_rls;
    assign w_free_cnt_nxt = r_free_cnt - w_grant_cnt + w_rls_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free_map <= '1;
            r_free_cnt <= CNT_W'(ENTRIES);
            r_dbl_rls  <= 1'b0;
        end else if (bus.i_flush) begin
            r_free_map <= '1;
            r_free_cnt <= CNT_W'(ENTRIES);
            r_dbl_rls  <= 1'b0;
        end else begin
            r_free_map <= w_free_map_nxt;
            r_free_cnt <= w_free_cnt_nxt;
            r_dbl_rls  <= w_dbl_rls;
        end
    end

    assign bus.o_alloc_idx = w_alloc_idx;
    assign bus.o_alloc_vld = w_alloc_vld;
    assign bus.o_alloc_rdy = w_alloc_rdy;
    assign bus.o_free_cnt  = r_free_cnt;
    assign bus.o_dbl_rls   = r_dbl_rls;

endmodule

`default_nettype wire

// File: tb/tb_gnrl_slot_alloc_module.sv
// ============================================================================
// tb_gnrl_slot_alloc_module : directed 64x4 and randomized 8x3 runs against a
// free-list reference model.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_gnrl_slot_alloc_module;
    localparam int E0 = 64;
    localparam int S0 = 4;
    localparam int E1 = 8;
    localparam int S1 = 3;
    localparam int IW0 = $clog2(E0);
    localparam int IW1 = $clog2(E1);

    logic        clk = 1'b0;
    logic        rst_n;
    int          act;
    logic        d_flush;
    int          d_alloc;
    logic [63:0] d_rls;

    int          n_ent;
    int          n_sel;
    bit          mfree [64];
    bit          mdbl;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    gnrl_slot_alloc_module_if #(.ENTRIES(E0), .SEL(S0)) bus0 ();
    gnrl_slot_alloc_module_if #(.ENTRIES(E1), .SEL(S1)) bus1 ();

    gnrl_slot_alloc_module #(.ENTRIES(E0), .SEL(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gnrl_slot_alloc_module #(.ENTRIES(E1), .SEL(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.i_flush     = (act == 0) && d_flush;
    assign bus0.i_alloc_cnt = (act == 0) ? 3'(d_alloc) : 3'd0;
    assign bus0.i_rls_vec   = (act == 0) ? d_rls : 64'd0;
    assign bus1.i_flush     = (act == 1) && d_flush;
    assign bus1.i_alloc_cnt = (act == 1) ? 2'(d_alloc) : 2'd0;
    assign bus1.i_rls_vec   = (act == 1) ? d_rls[7:0] : 8'd0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_idx(input int k);
        if (act == 0) return 64'(bus0.o_alloc_idx[k*IW0 +: IW0]);
        return 64'(bus1.o_alloc_idx[k*IW1 +: IW1]);
    endfunction

    function automatic logic [63:0] obs_vld();
        return (act == 0) ? 64'(bus0.o_alloc_vld) : 64'(bus1.o_alloc_vld);
    endfunction

    function automatic logic [63:0] obs_rdy();
        return (act == 0) ? 64'(bus0.o_alloc_rdy) : 64'(bus1.o_alloc_rdy);
    endfunction

    function automatic logic [63:0] obs_cnt();
        return (act == 0) ? 64'(bus0.o_free_cnt) : 64'(bus1.o_free_cnt);
    endfunction

    function automatic logic [63:0] obs_dbl();
        return (act == 0) ? 64'(bus0.o_dbl_rls) : 64'(bus1.o_dbl_rls);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 64; j++) mfree[j] = (j < n_ent);
        mdbl = 1'b0;
    endtask

    // Checks the current cycle against the model, then advances the model
    // across the next rising edge using the inputs that were presented.
    task automatic step();
        int          q[$];
        int          avail;
        bit          rdy;
        bit          nfree [64];
        bit          ndbl;
        logic [63:0] exp_vld;
        @(negedge clk);
        q = {};
        for (int j = 0; j < n_ent; j++) if (mfree[j]) q.push_back(j);
        avail   = (q.size() < n_sel) ? q.size() : n_sel;
        exp_vld = '0;
        for (int k = 0; k < n_sel; k++) begin
            if (k < avail) exp_vld[k] = 1'b1;
            check_val($sformatf("idx%0d", k), obs_idx(k), (k < avail) ? 64'(q[k]) : 64'd0);
        end
        check_val("vld", obs_vld(), exp_vld);
        rdy = (d_alloc <= avail);
        check_val("rdy", obs_rdy(), 64'(rdy));
        check_val("free_cnt", obs_cnt(), 64'(q.size()));
        check_val("dbl_rls", obs_dbl(), 64'(mdbl));
        ndbl = 1'b0;
        if (d_flush) begin
            for (int j = 0; j < 64; j++) nfree[j] = (j < n_ent);
        end else begin
            nfree = mfree;
            if (rdy && d_alloc > 0)
                for (int k = 0; k < d_alloc; k++) nfree[q[k]] = 1'b0;
            for (int j = 0; j < n_ent; j++) begin
                if (d_rls[j]) begin
                    if (mfree[j]) ndbl = 1'b1;
                    else          nfree[j] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        mfree = nfree;
        mdbl  = ndbl;
    endtask

    initial begin
        act     = 0;
        n_ent   = E0;
        n_sel   = S0;
        d_flush = 1'b0;
        d_alloc = 0;
        d_rls   = '0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check_val("rst_cnt", obs_cnt(), 64'd64);
        check_val("rst_vld", obs_vld(), 64'hf);
        check_val("rst_idx3", obs_idx(3), 64'd3);
        check_val("rst_dbl", obs_dbl(), 64'd0);
        step();

        d_alloc = 3; step(); d_alloc = 0;
        check_val("a3_idx0", obs_idx(0), 64'd3);
        check_val("a3_idx3", obs_idx(3), 64'd6);
        check_val("a3_cnt", obs_cnt(), 64'd61);
        d_rls = 64'd1 << 1; step(); d_rls = '0;
        check_val("r1_idx0", obs_idx(0), 64'd1);
        check_val("r1_cnt", obs_cnt(), 64'd62);
        step();

        d_flush = 1'b1; step(); d_flush = 1'b0;
        d_alloc = 4; repeat (16) step(); d_alloc = 0;
        check_val("full_cnt", obs_cnt(), 64'd0);
        check_val("full_vld", obs_vld(), 64'd0);
        d_alloc = 1; step();
        d_alloc = 0; step();
        d_rls = (64'd1 << 10) | (64'd1 << 63); step(); d_rls = '0;
        d_alloc = 3; step();
        d_alloc = 5; step();
        d_alloc = 2; step(); d_alloc = 0;
        check_val("a2_cnt", obs_cnt(), 64'd0);
        check_val("a2_vld", obs_vld(), 64'd0);
        check_val("a2_idx1", obs_idx(1), 64'd0);
        step();

        d_rls = 64'd1 << 5; step();
        d_rls = (64'd1 << 5) | (64'd1 << 7); step(); d_rls = '0;
        check_val("dbl_pulse", obs_dbl(), 64'd1);
        check_val("dbl_cnt", obs_cnt(), 64'd2);
        step();
        check_val("dbl_clear", obs_dbl(), 64'd0);
        d_alloc = 1; d_rls = 64'd1 << 5; step(); d_alloc = 0; d_rls = '0;
        step();

        d_flush = 1'b1; d_alloc = 4; d_rls = '1; step();
        d_flush = 1'b0; d_alloc = 0; d_rls = '0;
        check_val("fl_cnt", obs_cnt(), 64'd64);
        check_val("fl_vld", obs_vld(), 64'hf);
        check_val("fl_idx2", obs_idx(2), 64'd2);
        check_val("fl_dbl", obs_dbl(), 64'd0);
        step();

        d_alloc = 4; step(); step(); d_alloc = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_cnt", obs_cnt(), 64'd64);
        check_val("async_vld", obs_vld(), 64'hf);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        act   = 1;
        n_ent = E1;
        n_sel = S1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            d_flush = ($urandom_range(0, 49) == 0);
            d_alloc = $urandom_range(0, S1);
            d_rls   = 64'($urandom & $urandom & 32'hff);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
